model_vector_differentiation: RTL and testbench
===============================================

# model_vector_differentiation

Streaming first-order backward-difference engine for signed vectors: out[i] = in[i] − in[i−1], with in[−1] = 0. It sits directly downstream of the calculus stimulus generator driven by the calculus model package. It pulls one element at a time from the stimulus/memory source, emits one difference per element, and signals completion to the scoreboard. It is the reference datapath for the vector-differentiation test and cases 0/1.

## Interface
- DATA_SIZE, 64, element width, signed two's complement; SIZE_IN width.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  reset, asynchronous and active-high.
- START  in  1  one-cycle pulse; latches SIZE_IN; honoured only in IDLE.
- READY  out  1  one-cycle pulse when the vector is finished.
- SIZE_IN  in  DATA_SIZE  element count, unsigned.
- DATA_ENABLE  out  1  one-cycle request to upstream for the next element.
- DATA_IN_ENABLE  in  1  qualifies DATA_IN; honoured only in state INPUT.
- DATA_IN  in  DATA_SIZE  signed element.
- DATA_OUT_ENABLE  out  1  one-cycle pulse qualifying DATA_OUT.
- DATA_OUT  out  DATA_SIZE  signed difference; holds its value between pulses.

## Operation
- States: IDLE, INPUT, OUTPUT, DONE.
- IDLE: on START, latch size ← SIZE_IN, index ← 0, prev ← 0.
  - size ≠ 0: go to INPUT and assert DATA_ENABLE next cycle.
  - size = 0: go to DONE; no DATA_ENABLE, no DATA_OUT_ENABLE.
- INPUT: wait indefinitely for DATA_IN_ENABLE, then capture diff ← DATA_IN − prev and prev ← DATA_IN; go to OUTPUT.
- OUTPUT (one cycle): DATA_OUT ← diff and DATA_OUT_ENABLE = 1.
  - index = size−1: go to DONE.
  - Otherwise: index ← index+1, DATA_ENABLE = 1 in the same cycle, go to INPUT.
- DONE (one cycle): READY = 1; go to IDLE.
- Arithmetic: subtraction in DATA_SIZE+1 bits, result reduced per Configuration.
- START outside IDLE is ignored. DATA_IN_ENABLE outside INPUT is ignored; the element is dropped.
- DATA_IN_ENABLE in the same cycle DATA_ENABLE is first asserted is accepted.
- RST at any time, including mid-vector: state ← IDLE; index, size, prev, DATA_OUT ← 0; all enables and READY ← 0. The next START begins a fresh vector with prev = 0.

## Timing
- Reset values: READY = 0, DATA_ENABLE = 0, DATA_OUT_ENABLE = 0, DATA_OUT = 0.
- START at cycle t (size ≥ 1) gives DATA_ENABLE at t+1.
- Latency: DATA_IN_ENABLE at cycle u gives DATA_OUT_ENABLE at u+1.
- The next DATA_ENABLE coincides with DATA_OUT_ENABLE at u+1.
- Last DATA_OUT_ENABLE at cycle v gives READY at v+1; START is accepted again from v+2.
- Size 0: START at t gives READY at t+1.
- With zero upstream stall, throughput is 1 element per 2 cycles.

## Configuration
- MODEL_CALCULUS_SATURATE_EN defined: a difference outside the signed DATA_SIZE range clamps to 2^(DATA_SIZE−1)−1 or −2^(DATA_SIZE−1).
- Not defined: DATA_OUT is the low DATA_SIZE bits of the difference (wrap-around).
- Control timing is identical in both builds.

## Test plan
- Basic vector: SIZE_IN = 4, inputs 5, 8, 8, 3 → DATA_OUT 5, 3, 0, −5 on four DATA_OUT_ENABLE pulses; READY one cycle after the last pulse.
- Empty vector: SIZE_IN = 0, START at t → READY at t+1, no DATA_ENABLE, no DATA_OUT_ENABLE.
- Overflow: SIZE_IN = 2, inputs −2^63 then 1.
  - Outputs: 0x8000_0000_0000_0000, then 0x7FFF_FFFF_FFFF_FFFF with saturation or 0x8000_0000_0000_0001 without.
- Stall and spurious input:
  - Upstream delays DATA_IN_ENABLE 7 cycles per element → outputs unchanged and each DATA_OUT_ENABLE lands exactly 1 cycle after its DATA_IN_ENABLE.
  - DATA_IN_ENABLE pulsed in IDLE/OUTPUT → no effect.
- Reset mid-vector: RST after 2 of 4 elements (inputs 10, 20) → all outputs 0, no READY.
  - New START with SIZE_IN = 2, inputs 7, 9 → outputs 7, 2 (prev cleared).
- Back-to-back: START with SIZE_IN = 3, and START re-pulsed while busy → ignored, exactly 3 outputs.
  - START on the first legal cycle after READY → second vector processed correctly.

Source files
------------

// File: rtl/model_vector_differentiation_if.sv
// Handshake bundle between the stimulus/memory source, the differentiation
// engine and the scoreboard. The engine connects through the slave modport.
interface model_vector_differentiation_if #(
  parameter int unsigned DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_IN;
  logic                 DATA_ENABLE;
  logic                 DATA_IN_ENABLE;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic                 DATA_OUT_ENABLE;
  logic [DATA_SIZE-1:0] DATA_OUT;

  modport master (
    output START, SIZE_IN, DATA_IN_ENABLE, DATA_IN,
    input  READY, DATA_ENABLE, DATA_OUT_ENABLE, DATA_OUT
  );

  modport slave (
    input  START, SIZE_IN, DATA_IN_ENABLE, DATA_IN,
    output READY, DATA_ENABLE, DATA_OUT_ENABLE, DATA_OUT
  );
endinterface

// File: rtl/model_vector_differentiation.sv
// Streaming backward-difference engine: out[i] = in[i] - in[i-1], in[-1] = 0.
// Define MODEL_CALCULUS_SATURATE_EN to clamp out-of-range differences instead of wrapping.
module model_vector_differentiation #(
  parameter int unsigned DATA_SIZE = 64
) (
  input logic                          CLK,
  input logic                          RST,
  model_vector_differentiation_if.slave bus
);

  typedef enum logic [1:0] {IDLE, INPUT, OUTPUT, DONE} state_t;

  state_t               state;
  logic [DATA_SIZE-1:0] size;
  logic [DATA_SIZE-1:0] index;
  logic [DATA_SIZE-1:0] prev;
  logic [DATA_SIZE-1:0] diff;
  logic                 last;

  logic                 ready_r;
  logic                 data_enable_r;
  logic                 data_out_enable_r;
  logic [DATA_SIZE-1:0] data_out_r;

  assign bus.READY           = ready_r;
  assign bus.DATA_ENABLE     = data_enable_r;
  assign bus.DATA_OUT_ENABLE = data_out_enable_r;
  assign bus.DATA_OUT        = data_out_r;

  assign last = (index == size - 1'b1);

`ifdef MODEL_CALCULUS_SATURATE_EN
  logic [DATA_SIZE:0] diff_full;

  always_comb begin
    diff_full = {bus.DATA_IN[DATA_SIZE-1], bus.DATA_IN} - {prev[DATA_SIZE-1], prev};
    diff      = diff_full[DATA_SIZE-1:0];
    // Top two bits disagree only when the true difference left the signed range.
    if (diff_full[DATA_SIZE] != diff_full[DATA_SIZE-1])
      diff = diff_full[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                  : {1'b0, {(DATA_SIZE-1){1'b1}}};
  end
`else
  always_comb begin
    diff = bus.DATA_IN - prev;
  end
`endif

  // DATA_OUT is registered at capture time so it is already valid during OUTPUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state             <= IDLE;
      size              <= '0;
      index             <= '0;
      prev              <= '0;
      ready_r           <= 1'b0;
      data_enable_r     <= 1'b0;
      data_out_enable_r <= 1'b0;
      data_out_r        <= '0;
    end else begin
      ready_r           <= 1'b0;
      data_enable_r     <= 1'b0;
      data_out_enable_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            size  <= bus.SIZE_IN;
            index <= '0;
            prev  <= '0;
            if (bus.SIZE_IN != '0) begin
              state         <= INPUT;
              data_enable_r <= 1'b1;
            end else begin
              state   <= DONE;
              ready_r <= 1'b1;
            end
          end
        end
        INPUT: begin
          if (bus.DATA_IN_ENABLE) begin
            prev              <= bus.DATA_IN;
            data_out_r        <= diff;
            data_out_enable_r <= 1'b1;
            data_enable_r     <= !last;
            state             <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (last) begin
            state   <= DONE;
            ready_r <= 1'b1;
          end else begin
            index <= index + 1'b1;
            state <= INPUT;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_vector_differentiation.sv
// Self-checking bench for model_vector_differentiation: directed scenarios plus
// randomized vectors compared against a backward-difference reference model.
module tb_model_vector_differentiation;

  localparam int DS = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
`ifdef MODEL_CALCULUS_SATURATE_EN
  localparam logic [63:0] OVF_EXP = MAX64;
`else
  localparam logic [63:0] OVF_EXP = 64'h8000_0000_0000_0001;
`endif

  logic CLK = 1'b0;
  logic RST;

  model_vector_differentiation_if #(.DATA_SIZE(DS)) bus ();
  model_vector_differentiation #(.DATA_SIZE(DS)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] out_q[$];
  int unsigned out_cyc[$];
  int unsigned ready_cyc[$];
  int unsigned ine_cyc[$];
  int unsigned de_count;
  int unsigned start_cyc;
  bit          feed_timeout;

  always @(negedge CLK) begin
    if (bus.DATA_OUT_ENABLE) begin
      out_q.push_back(bus.DATA_OUT);
      out_cyc.push_back(cyc);
    end
    if (bus.READY) ready_cyc.push_back(cyc);
    if (bus.DATA_ENABLE) de_count++;
  end

  // Reference: exact signed difference, then clamp or keep the low 64 bits.
  function automatic logic [63:0] ref_diff(input logic signed [63:0] cur,
                                           input logic signed [63:0] prv);
    logic signed [64:0] d;
    d = 65'(cur) - 65'(prv);
`ifdef MODEL_CALCULUS_SATURATE_EN
    if (d > 65'sd9223372036854775807)  return MAX64;
    if (d < -65'sd9223372036854775808) return MIN64;
`endif
    return d[63:0];
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 5))
      0:       return MIN64;
      1:       return MAX64;
      2:       return 64'($signed($urandom_range(0, 40)) - 20);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic clear_mon();
    out_q.delete();
    out_cyc.delete();
    ready_cyc.delete();
    ine_cyc.delete();
    de_count = 0;
  endtask

  task automatic start_vec(input logic [63:0] n);
    bus.SIZE_IN = n;
    bus.START   = 1'b1;
    start_cyc   = cyc;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  // Upstream source: answers each DATA_ENABLE after a latency, optionally
  // holding a junk DATA_IN_ENABLE during the OUTPUT cycle.
  task automatic feed(input logic [63:0] vals[$], input int first_lat,
                      input int lat, input bit spur);
    feed_timeout = 1'b0;
    foreach (vals[i]) begin
      int w = 0;
      while (!bus.DATA_ENABLE && w < 64) begin
        @(negedge CLK);
        w++;
      end
      if (!bus.DATA_ENABLE) begin
        feed_timeout = 1'b1;
        break;
      end
      if (spur && i > 0) begin
        bus.DATA_IN        = {$urandom, $urandom};
        bus.DATA_IN_ENABLE = 1'b1;
      end
      repeat (i == 0 ? first_lat : lat) begin
        @(negedge CLK);
        bus.DATA_IN_ENABLE = 1'b0;
      end
      bus.DATA_IN        = vals[i];
      bus.DATA_IN_ENABLE = 1'b1;
      ine_cyc.push_back(cyc);
      @(negedge CLK);
      bus.DATA_IN_ENABLE = 1'b0;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++; if (bus.READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.READY); end
    n_checks++; if (bus.DATA_ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", bus.DATA_ENABLE); end
    n_checks++; if (bus.DATA_OUT_ENABLE !== 1'b0) begin n_fail++; $display("FAIL reset_doe: got %b want 0", bus.DATA_OUT_ENABLE); end
    n_checks++; if (bus.DATA_OUT !== 64'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", bus.DATA_OUT); end
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [63:0] vals[$] = '{64'd5, 64'd8, 64'd8, 64'd3};
    logic [63:0] exp[$]  = '{64'd5, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB};
    clear_mon();
    start_vec(4);
    n_checks++; if (bus.DATA_ENABLE !== 1'b1) begin n_fail++; $display("FAIL basic_first_de: got %b want 1 at start+1", bus.DATA_ENABLE); end
    feed(vals, 0, 1, 1'b0);
    repeat (4) @(negedge CLK);
    n_checks++; if (feed_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: DATA_ENABLE never came"); end
    n_checks++; if (out_q.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL basic_out[%0d]: got %h want %h", i, out_q[i], exp[i]); end
      n_checks++; if (out_cyc[i] != ine_cyc[i] + 1) begin n_fail++; $display("FAIL basic_lat[%0d]: got cycle %0d want %0d", i, out_cyc[i], ine_cyc[i] + 1); end
    end
    n_checks++; if (ready_cyc.size() != 1 || out_cyc.size() != 4 || ready_cyc[0] != out_cyc[3] + 1) begin n_fail++; $display("FAIL basic_ready: got %0d pulses want 1 pulse after last output", ready_cyc.size()); end
    n_checks++; if (de_count != 4) begin n_fail++; $display("FAIL basic_de_count: got %0d want 4", de_count); end
    n_checks++; if (bus.DATA_OUT !== exp[3]) begin n_fail++; $display("FAIL basic_hold: got %h want %h", bus.DATA_OUT, exp[3]); end
  endtask

  task automatic test_empty();
    clear_mon();
    start_vec(0);
    n_checks++; if (bus.READY !== 1'b1) begin n_fail++; $display("FAIL empty_ready: got %b want 1 at start+1", bus.READY); end
    repeat (5) @(negedge CLK);
    n_checks++; if (de_count != 0) begin n_fail++; $display("FAIL empty_de: got %0d want 0", de_count); end
    n_checks++; if (out_q.size() != 0) begin n_fail++; $display("FAIL empty_doe: got %0d want 0", out_q.size()); end
    n_checks++; if (ready_cyc.size() != 1) begin n_fail++; $display("FAIL empty_ready_count: got %0d want 1", ready_cyc.size()); end
  endtask

  task automatic test_overflow();
    logic [63:0] vals[$] = '{MIN64, 64'd1};
    clear_mon();
    start_vec(2);
    feed(vals, 1, 1, 1'b0);
    repeat (4) @(negedge CLK);
    n_checks++; if (out_q.size() != 2) begin n_fail++; $display("FAIL ovf_count: got %0d want 2", out_q.size()); end
    n_checks++; if (out_q.size() > 0 && out_q[0] !== MIN64) begin n_fail++; $display("FAIL ovf_out0: got %h want %h", out_q[0], MIN64); end
    n_checks++; if (out_q.size() > 1 && out_q[1] !== OVF_EXP) begin n_fail++; $display("FAIL ovf_out1: got %h want %h", out_q[1], OVF_EXP); end
  endtask

  task automatic test_stall();
    logic [63:0] vals[$];
    for (int i = 0; i < 3; i++) vals.push_back(rand64());
    clear_mon();
    bus.DATA_IN = 64'd123;
    bus.DATA_IN_ENABLE = 1'b1;
    repeat (2) @(negedge CLK);
    bus.DATA_IN_ENABLE = 1'b0;
    @(negedge CLK);
    start_vec(3);
    feed(vals, 7, 7, 1'b1);
    repeat (4) @(negedge CLK);
    n_checks++; if (feed_timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: DATA_ENABLE never came"); end
    n_checks++; if (out_q.size() != 3) begin n_fail++; $display("FAIL stall_count: got %0d want 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      logic [63:0] e = ref_diff(vals[i], (i == 0) ? 64'd0 : vals[i-1]);
      n_checks++; if (out_q[i] !== e) begin n_fail++; $display("FAIL stall_out[%0d]: got %h want %h", i, out_q[i], e); end
      n_checks++; if (out_cyc[i] != ine_cyc[i] + 1) begin n_fail++; $display("FAIL stall_lat[%0d]: got cycle %0d want %0d", i, out_cyc[i], ine_cyc[i] + 1); end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] v1[$] = '{64'd10, 64'd20};
    logic [63:0] v2[$] = '{64'd7, 64'd9};
    clear_mon();
    start_vec(4);
    feed(v1, 1, 1, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    n_checks++; if (bus.DATA_OUT !== 64'h0 || bus.DATA_ENABLE !== 1'b0 || bus.DATA_OUT_ENABLE !== 1'b0 || bus.READY !== 1'b0)
      begin n_fail++; $display("FAIL midrst_outputs: got dout=%h de=%b doe=%b rdy=%b want all 0", bus.DATA_OUT, bus.DATA_ENABLE, bus.DATA_OUT_ENABLE, bus.READY); end
    n_checks++; if (out_q.size() != 2 || out_q[0] !== 64'd10 || out_q[1] !== 64'd10) begin n_fail++; $display("FAIL midrst_pre: got %0d outputs want 10,10", out_q.size()); end
    RST = 1'b0;
    clear_mon();
    repeat (6) @(negedge CLK);
    n_checks++; if (ready_cyc.size() != 0 || de_count != 0 || out_q.size() != 0) begin n_fail++; $display("FAIL midrst_quiet: got ready=%0d de=%0d out=%0d want 0", ready_cyc.size(), de_count, out_q.size()); end
    start_vec(2);
    feed(v2, 1, 1, 1'b0);
    repeat (4) @(negedge CLK);
    n_checks++; if (out_q.size() != 2) begin n_fail++; $display("FAIL midrst_count: got %0d want 2", out_q.size()); end
    n_checks++; if (out_q.size() > 0 && out_q[0] !== 64'd7) begin n_fail++; $display("FAIL midrst_out0: got %h want 7", out_q[0]); end
    n_checks++; if (out_q.size() > 1 && out_q[1] !== 64'd2) begin n_fail++; $display("FAIL midrst_out1: got %h want 2", out_q[1]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v1[$];
    logic [63:0] v2[$];
    logic [63:0] all[$];
    logic [63:0] exp[$];
    int w = 0;
    for (int i = 0; i < 3; i++) v1.push_back(rand64());
    for (int i = 0; i < 2; i++) v2.push_back(rand64());
    foreach (v1[i]) exp.push_back(ref_diff(v1[i], (i == 0) ? 64'd0 : v1[i-1]));
    foreach (v2[i]) exp.push_back(ref_diff(v2[i], (i == 0) ? 64'd0 : v2[i-1]));
    clear_mon();
    start_vec(3);
    fork
      feed(v1, 1, 1, 1'b0);
      begin
        repeat (2) @(negedge CLK);
        bus.SIZE_IN = 5;
        bus.START   = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
      end
    join
    while (!bus.READY && w < 20) begin
      @(negedge CLK);
      w++;
    end
    n_checks++; if (bus.READY !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.READY); end
    @(negedge CLK);
    start_vec(2);
    feed(v2, 1, 1, 1'b0);
    repeat (4) @(negedge CLK);
    n_checks++; if (out_q.size() != 5) begin n_fail++; $display("FAIL b2b_count: got %0d want 5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      n_checks++; if (out_q[i] !== exp[i]) begin n_fail++; $display("FAIL b2b_out[%0d]: got %h want %h", i, out_q[i], exp[i]); end
    end
    n_checks++; if (ready_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_ready_count: got %0d want 2", ready_cyc.size()); end
  endtask

  task automatic test_random();
    for (int v = 0; v < 20; v++) begin
      logic [63:0] vals[$];
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) vals.push_back(rand64());
      clear_mon();
      start_vec(64'(n));
      feed(vals, $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
      repeat (4) @(negedge CLK);
      n_checks++; if (out_q.size() != n || feed_timeout) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", v, out_q.size(), n); end
      for (int i = 0; i < n && i < out_q.size(); i++) begin
        logic [63:0] e = ref_diff(vals[i], (i == 0) ? 64'd0 : vals[i-1]);
        n_checks++; if (out_q[i] !== e) begin n_fail++; $display("FAIL rand%0d_out[%0d]: got %h want %h", v, i, out_q[i], e); end
      end
      n_checks++; if (ready_cyc.size() != 1 || out_cyc.size() == 0 || ready_cyc[0] != out_cyc[out_cyc.size()-1] + 1)
        begin n_fail++; $display("FAIL rand%0d_ready: got %0d pulses want 1 right after last output", v, ready_cyc.size()); end
    end
  endtask

  initial begin
    bus.START = 1'b0;
    bus.SIZE_IN = '0;
    bus.DATA_IN_ENABLE = 1'b0;
    bus.DATA_IN = '0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_empty();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
